// File: rtl/c5315_reg_alu.sv
// c5315_reg_alu: registered dual-channel 9-bit ALU benchmark core.
//
// Each channel computes {par, zero, cout, res[8:0]} from its operands and
// opcode. A selector muxes one channel's result. The otherwise unused input
// bits are folded into a pairwise-XOR field.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high; clears all state
//   in_valid   in_vec is valid this cycle
//   in_vec     178-bit packed input vector
//   out_valid  out_vec was updated by the last edge
//   out_vec    123-bit packed registered output vector
//
// Build option:
//   C5315_INPUT_REG_EN  adds an input register stage, so latency becomes 2 cycles.
module c5315_reg_alu #(
  parameter int unsigned IN_W  = 178,
  parameter int unsigned OUT_W = 123
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_vec,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_vec
);

  // Result packed as {par, zero, cout, res[8:0]}.
  function automatic logic [11:0] alu_ch(input logic [8:0] a, input logic [8:0] b,
                                         input logic [3:0] op, input logic cin);
    logic [9:0] sum;
    logic [8:0] res;
    logic       cout;
    sum  = '0;
    res  = '0;
    cout = 1'b0;
    unique case (op)
      4'd0: begin
        sum  = {1'b0, a} + {1'b0, b} + {9'd0, cin};
        res  = sum[8:0];
        cout = sum[9];
      end
      4'd1: begin
        // Carry out of a + ~b + 1 is set when no borrow occurs.
        sum  = {1'b0, a} + {1'b0, ~b} + 10'd1;
        res  = sum[8:0];
        cout = sum[9];
      end
      4'd2: res = a & b;
      4'd3: res = a | b;
      4'd4: res = a ^ b;
      4'd5: res = ~a;
      4'd6: begin
        sum  = {1'b0, a} + 10'd1;
        res  = sum[8:0];
        cout = sum[9];
      end
      4'd7: begin
        // a + 0x1FF: carry set unless a was zero (no borrow).
        sum  = {1'b0, a} + 10'h1FF;
        res  = sum[8:0];
        cout = sum[9];
      end
      4'd8: begin
        res  = {a[7:0], 1'b0};
        cout = a[8];
      end
      4'd9: begin
        res  = {1'b0, a[8:1]};
        cout = a[0];
      end
      4'd10:   res = a;
      4'd11:   res = b;
      default: res = '0;
    endcase
    return {^res, (res == 9'd0), cout, res};
  endfunction

  // Stage feeding the compute/output register.
  logic [IN_W-1:0] s_vec;
  logic            s_valid;

`ifdef C5315_INPUT_REG_EN
  logic [IN_W-1:0] in_vec_d, in_vec_q;
  logic            in_valid_d, in_valid_q;

  always_comb begin
    in_valid_d = in_valid;
    in_vec_d   = in_valid ? in_vec : in_vec_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_valid_q <= 1'b0;
      in_vec_q   <= '0;
    end else begin
      in_valid_q <= in_valid_d;
      in_vec_q   <= in_vec_d;
    end
  end

  assign s_vec   = in_vec_q;
  assign s_valid = in_valid_q;
`else
  assign s_vec   = in_vec;
  assign s_valid = in_valid;
`endif

  logic [11:0]      ch0, ch1;
  logic [OUT_W-1:0] result;
  logic [OUT_W-1:0] out_vec_d, out_vec_q;
  logic             out_valid_d, out_valid_q;

  always_comb begin
    ch0 = alu_ch(s_vec[8:0], s_vec[17:9], s_vec[39:36], s_vec[44]);
    ch1 = alu_ch(s_vec[26:18], s_vec[35:27], s_vec[43:40], s_vec[45]);
    result          = '0;
    result[11:0]    = ch0;
    result[23:12]   = ch1;
    result[32:24]   = s_vec[46] ? ch1[8:0] : ch0[8:0];
    result[33]      = (ch0[8:0] == ch1[8:0]);
    result[34]      = ^s_vec;
    result[122:35]  = s_vec[134:47] ^ s_vec[177:90];
    out_valid_d     = s_valid;
    out_vec_d       = s_valid ? result : out_vec_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_vec_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_vec_q   <= out_vec_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_vec   = out_vec_q;

endmodule

// File: tb/tb_c5315_reg_alu.sv
// Testbench for c5315_reg_alu: directed scenarios plus random stream checked
// against a behavioural model through an expected-output queue.
module tb_c5315_reg_alu;

`ifdef C5315_INPUT_REG_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 1;
`endif

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [177:0] in_vec;
  logic         out_valid;
  logic [122:0] out_vec;

  int checks   = 0;
  int failures = 0;

  logic [122:0] exp_q[$];
  logic [122:0] last_out;

  c5315_reg_alu dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_vec   (out_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [122:0] got, input logic [122:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int ones(input int x);
    int n = 0;
    for (int i = 0; i < 9; i++) n += (x >> i) & 1;
    return n;
  endfunction

  // Returns {par, zero, cout, res} for one channel using integer arithmetic.
  function automatic logic [11:0] ref_ch(input int a, input int b, input int op, input int cin);
    int r = 0;
    int c = 0;
    case (op)
      0: begin r = a + b + cin; c = (r >= 512) ? 1 : 0; end
      1: begin r = a - b + 512; c = (a >= b) ? 1 : 0; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 511 - a;
      6: begin r = a + 1; c = (a == 511) ? 1 : 0; end
      7: begin r = a + 511; c = (a != 0) ? 1 : 0; end
      8: begin r = a * 2; c = (a >= 256) ? 1 : 0; end
      9: begin r = a / 2; c = a % 2; end
      10: r = a;
      11: r = b;
      default: r = 0;
    endcase
    r = r % 512;
    return {1'(ones(r) % 2), 1'(r == 0), 1'(c), 9'(r)};
  endfunction

  function automatic logic [122:0] model(input logic [177:0] v);
    logic [122:0] o;
    logic [11:0]  c0, c1;
    int           p;
    c0 = ref_ch(int'(v[8:0]), int'(v[17:9]), int'(v[39:36]), int'(v[44]));
    c1 = ref_ch(int'(v[26:18]), int'(v[35:27]), int'(v[43:40]), int'(v[45]));
    o = '0;
    o[11:0]  = c0;
    o[23:12] = c1;
    o[32:24] = v[46] ? c1[8:0] : c0[8:0];
    o[33]    = (c0[8:0] == c1[8:0]);
    p = 0;
    for (int i = 0; i < 178; i++) p += int'(v[i]);
    o[34] = 1'(p % 2);
    for (int k = 0; k < 88; k++) o[35+k] = v[47+k] ^ v[90+k];
    return o;
  endfunction

  function automatic logic [177:0] rand_vec();
    logic [191:0] w;
    w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return w[177:0];
  endfunction

  // Monitor: one decision per rising edge, sampled just after it.
  initial begin
    logic r;
    logic [122:0] e;
    last_out = '0;
    forever begin
      @(posedge clk);
      r = rst;
      #1;
      if (r) begin
        check("rst_out_vec", out_vec, '0);
        check("rst_out_valid", 123'(out_valid), '0);
        exp_q.delete();
        last_out = '0;
      end else if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", 123'(1), 123'(0));
        end else begin
          e = exp_q.pop_front();
          check("sb_out_vec", out_vec, e);
          last_out = e;
        end
      end else begin
        check("hold_out_vec", out_vec, last_out);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  initial begin
    logic [177:0] v;
    logic [122:0] saved;
    int n;

    rst = 1'b1;
    in_valid = 1'b1;
    in_vec = '1;
    repeat (2) @(negedge clk);
    check("reset_valid", 123'(out_valid), '0);
    check("reset_vec", out_vec, '0);
    rst = 1'b0;
    in_valid = 1'b0;
    idle(2);

    // Combined directed vector: ADD wrap on ch0, SUB borrow on ch1, sel=1.
    v = '0;
    v[8:0] = 9'h1FF;
    v[17:9] = 9'h001;
    v[26:18] = 9'd5;
    v[35:27] = 9'd7;
    v[43:40] = 4'd1;
    v[46] = 1'b1;
    v[47] = 1'b1;
    @(negedge clk);
    in_vec = v;
    in_valid = 1'b1;
    exp_q.push_back(model(v));
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 8) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("latency", 123'(n), 123'(Lat));
    check("ch0_add_wrap", 123'(out_vec[11:0]), 123'(12'h600));
    check("ch1_sub_borrow", 123'(out_vec[23:12]), 123'(12'h1FE));
    check("sel_mux", 123'(out_vec[32:24]), 123'(9'h1FE));
    check("res_eq", 123'(out_vec[33]), 123'(0));
    check("parity_all", 123'(out_vec[34]), 123'(0));
    check("pair_xor0", 123'(out_vec[35]), 123'(1));
    saved = out_vec;

    idle(3);
    #2;
    check("idle_valid", 123'(out_valid), '0);
    check("idle_hold", out_vec, saved);

    // Random stream with gaps and one mid-stream reset.
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      v = rand_vec();
      if (i % 4 == 0) v[39:36] = 4'(i / 4);
      if (i % 4 == 1) v[43:40] = 4'(i / 4);
      in_vec = v;
      rst = (i == 30);
      in_valid = ($urandom_range(3) != 0);
      if (in_valid && !rst) exp_q.push_back(model(v));
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    idle(Lat + 3);
    check("drain", 123'(exp_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
